trace_packer: RTL and testbench

//  Upstream feeder of the input buffer. Accepts M-lane trace beats from the instrumented

---
 rtl/lebug_pkg.sv | 20 ++
 rtl/trace_packer.sv | 99 +++++++++
 tb/tb_trace_packer.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/lebug_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lebug_pkg : shared lane type and packing geometry for trace_packer    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package lebug_pkg;

   localparam int N          = 8;
   localparam int DATA_WIDTH = 32;
   localparam int M          = 2;
   localparam int BEATS      = N / M;

   typedef logic [DATA_WIDTH-1:0] lane_t;

   function automatic int cnt_width(input int beats);
      return (beats > 1) ? $clog2(beats) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/trace_packer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | trace_packer : packs M-lane trace beats into N-lane enqueue vectors   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module trace_packer
   import lebug_pkg::*;
#(
   parameter int N          = lebug_pkg::N,
   parameter int DATA_WIDTH = lebug_pkg::DATA_WIDTH,
   parameter int M          = lebug_pkg::M
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic                           valid_in,
   input  logic                           eof_in,
   input  logic                           tracing,
   input  logic [M-1:0][DATA_WIDTH-1:0]   data_in,
   output logic                           enqueue,
   output logic                           eof_out,
   output logic [N-1:0][DATA_WIDTH-1:0]   vector_out,
   output logic [15:0]                    frame_count
);

   localparam int               c_BEATS     = N / M;
   localparam int               c_CW        = cnt_width(c_BEATS);
   localparam logic [c_CW-1:0]  c_LAST_BEAT = c_CW'(c_BEATS - 1);

   generate
      if ((M < 1) || (M > N) || ((N % M) != 0)) begin : g_param_check
         $error("trace_packer: N must be a non-zero multiple of M");
      end
   endgenerate

   logic [c_CW-1:0]                 r_cnt;
   logic [N-1:0][DATA_WIDTH-1:0]    r_shadow;
   logic                            r_tracing_q;
   logic                            r_enqueue;
   logic                            r_eof;
   logic [N-1:0][DATA_WIDTH-1:0]    r_vector;
   logic [15:0]                     r_frame_count;

   logic                            w_accept;
   logic                            w_close;
   logic                            w_flush;
   logic [N-1:0][DATA_WIDTH-1:0]    w_merged;

   assign w_accept = valid_in & tracing;
   assign w_close  = w_accept & ((r_cnt == c_LAST_BEAT) | eof_in);
   // A falling tracing edge can never coincide with an accepted beat.
   assign w_flush  = r_tracing_q & ~tracing & (r_cnt != '0);

   always_comb begin
      w_merged = r_shadow;
      for (int j = 0; j < M; j++) begin
         w_merged[int'(r_cnt) * M + j] = data_in[j];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt         <= '0;
         r_shadow      <= '0;
         r_tracing_q   <= 1'b0;
         r_enqueue     <= 1'b0;
         r_eof         <= 1'b0;
         r_vector      <= '0;
         r_frame_count <= '0;
      end else begin
         r_tracing_q <= tracing;
         r_enqueue   <= w_close | w_flush;
         if (w_close) begin
            r_vector <= w_merged;
            r_eof    <= eof_in;
            r_cnt    <= '0;
            r_shadow <= '0;
            if (eof_in) begin
               r_frame_count <= r_frame_count + 16'd1;
            end
         end else if (w_flush) begin
            r_vector      <= r_shadow;
            r_eof         <= 1'b1;
            r_cnt         <= '0;
            r_shadow      <= '0;
            r_frame_count <= r_frame_count + 16'd1;
         end else if (w_accept) begin
            r_shadow <= w_merged;
            r_cnt    <= r_cnt + 1'b1;
         end
      end
   end

   assign enqueue     = r_enqueue;
   assign eof_out     = r_eof;
   assign vector_out  = r_vector;
   assign frame_count = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_trace_packer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_trace_packer : randomized and directed bench for trace_packer      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_trace_packer;

   localparam int N  = 8;
   localparam int DW = 32;
   localparam int M  = 2;

   logic                     clk = 1'b0;
   logic                     reset_n;
   logic                     valid_in;
   logic                     eof_in;
   logic                     tracing;
   logic [M-1:0][DW-1:0]     data_in;
   logic                     enqueue;
   logic                     eof_out;
   logic [N-1:0][DW-1:0]     vector_out;
   logic [15:0]              frame_count;

   trace_packer #(.N(N), .DATA_WIDTH(DW), .M(M)) u_dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .valid_in    (valid_in),
      .eof_in      (eof_in),
      .tracing     (tracing),
      .data_in     (data_in),
      .enqueue     (enqueue),
      .eof_out     (eof_out),
      .vector_out  (vector_out),
      .frame_count (frame_count)
   );

   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   // Reference model: accepted elements in arrival order, plus expected outputs.
   logic [31:0]  m_pend[$];
   logic         m_prev_tr;
   logic         exp_enq;
   logic [255:0] exp_vec;
   logic         exp_eof;
   logic [15:0]  exp_fc;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pend.delete();
      m_prev_tr = 1'b0;
      exp_enq   = 1'b0;
      exp_vec   = '0;
      exp_eof   = 1'b0;
      exp_fc    = '0;
   endtask

   task automatic emit(input logic eof);
      exp_vec = '0;
      foreach (m_pend[i]) exp_vec[i*32 +: 32] = m_pend[i];
      exp_eof = eof;
      exp_enq = 1'b1;
      if (eof) exp_fc = exp_fc + 16'd1;
      m_pend.delete();
   endtask

   task automatic check_outputs();
      chk("enqueue",     {255'd0, enqueue},     {255'd0, exp_enq});
      chk("vector_out",  vector_out,            exp_vec);
      chk("eof_out",     {255'd0, eof_out},     {255'd0, exp_eof});
      chk("frame_count", {240'd0, frame_count}, {240'd0, exp_fc});
   endtask

   task automatic step(input logic v, input logic e, input logic t,
                       input logic [31:0] d0, input logic [31:0] d1);
      valid_in   = v;
      eof_in     = e;
      tracing    = t;
      data_in[0] = d0;
      data_in[1] = d1;
      @(posedge clk);
      exp_enq = 1'b0;
      if (v && t) begin
         m_pend.push_back(d0);
         m_pend.push_back(d1);
         if (e || m_pend.size() == N) emit(e);
      end else if (m_prev_tr && !t && m_pend.size() != 0) begin
         emit(1'b1);
      end
      m_prev_tr = t;
      #1;
      check_outputs();
   endtask

   initial begin
      reset_n  = 1'b0;
      valid_in = 1'b0;
      eof_in   = 1'b0;
      tracing  = 1'b0;
      data_in  = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_outputs();
      reset_n = 1'b1;

      // Full vector, then early eof, then flush with a dropped falling-cycle beat.
      step(1, 0, 1, 1, 2);  step(1, 0, 1, 3, 4);
      step(1, 0, 1, 5, 6);  step(1, 0, 1, 7, 8);
      step(0, 0, 1, 0, 0);
      step(1, 0, 1, 9, 10); step(1, 1, 1, 11, 12);
      step(0, 0, 1, 0, 0);
      step(1, 0, 1, 21, 22); step(1, 0, 1, 23, 24); step(1, 0, 1, 25, 26);
      step(1, 0, 0, 99, 98);
      step(0, 0, 0, 0, 0);

      // Gated input: nothing is captured while tracing is low.
      for (int i = 0; i < 20; i++) step(i[0], i[1], 0, 32'(i), 32'(i + 100));
      for (int i = 0; i < 8; i++) step(1, 0, 1, 32'(2*i + 40), 32'(2*i + 41));
      step(0, 0, 1, 0, 0);

      // Mid-stream reset discards the partial vector.
      step(1, 0, 1, 77, 78); step(1, 0, 1, 79, 80);
      #2 reset_n = 1'b0;
      #1;
      model_reset();
      check_outputs();
      @(posedge clk);
      #1 reset_n = 1'b1;
      for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0);

      // Randomized traffic, tracing occasionally dropping.
      for (int i = 0; i < 2000; i++) begin
         step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0),
              1'($urandom_range(0, 15) != 0), $urandom, $urandom);
      end
      step(0, 0, 0, 0, 0);

      // Single-beat eof frames drive frame_count through its wrap.
      for (int i = 0; i < 65536; i++) step(1, 1, 1, 32'(i), ~32'(i));
      step(0, 0, 1, 0, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
